// File: rtl/act_lut_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : act_lut_pkg
// Brief    : Shared widths, tag-width helper and response stage record for
//            the activation-LUT arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package act_lut_pkg;

  localparam int ACT_LUT_ADDR_W = 11;
  localparam int ACT_LUT_DATA_W = 8;

  // Tag storage is sized for the largest legal lane count (16).
  localparam int RSP_TAG_W = 4;

  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [RSP_TAG_W-1:0] tag;
  } rsp_stage_t;

endpackage
`default_nettype wire

// File: rtl/act_lut_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; grants the first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import act_lut_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = tag_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cidx;
  int               w_cand;

  // Scan lanes starting at ptr; wrap is a single subtract since ptr < N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    w_cand  = 0;
    w_cidx  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = int'(r_ptr) + k;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      w_cidx = IDX_W'(w_cand);
      if (!gnt_vld && req[w_cidx]) begin
        gnt_vld      = 1'b1;
        gnt_idx      = w_cidx;
        gnt[w_cidx]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (gnt_vld) begin
      r_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/act_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : act_lut_arbiter
// Brief    : Shares one 2048x8 activation ROM between NUM_REQ lanes; routes
//            the read data back with a one-hot response strobe.
//            Optional macro ACT_LUT_OUTREG_EN adds a registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module act_lut_arbiter
  import act_lut_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ACT_LUT_ADDR_W,
  parameter int DATA_W  = ACT_LUT_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int TAG_W = tag_width(NUM_REQ);

  logic [NUM_REQ-1:0] w_gnt;
  logic [TAG_W-1:0]   w_gnt_idx;
  logic               w_gnt_vld;
  rsp_stage_t         r_s1;
  rsp_stage_t         w_out;

  rr_arbiter #(
    .N       (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_vld (w_gnt_vld)
  );

  assign req_ready = w_gnt;

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        rom_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Stage 1 lines up with the ROM's own registered read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
    end else begin
      r_s1.valid <= w_gnt_vld;
      r_s1.tag   <= RSP_TAG_W'(w_gnt_idx);
    end
  end

`ifdef ACT_LUT_OUTREG_EN
  rsp_stage_t        r_s2;
  logic [DATA_W-1:0] r_s2_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2      <= '0;
      r_s2_data <= '0;
    end else begin
      r_s2      <= r_s1;
      r_s2_data <= r_s1.valid ? rom_q : '0;
    end
  end

  assign w_out    = r_s2;
  assign rsp_data = r_s2_data;
  assign busy     = r_s1.valid | r_s2.valid;
`else
  // rom_q is never reset, so hold the data bus at zero between responses.
  assign w_out    = r_s1;
  assign rsp_data = r_s1.valid ? rom_q : '0;
  assign busy     = r_s1.valid;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_valid[i] = w_out.valid && (w_out.tag == RSP_TAG_W'(i));
  end

endmodule
`default_nettype wire

// File: tb/tb_act_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_lut_arbiter
// Brief    : Self-checking bench for act_lut_arbiter with a behavioural ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_lut_arbiter;

  localparam int N = 4;
`ifdef ACT_LUT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic [3:0]    rv;
  logic [10:0]   addr [0:3];
  logic [43:0]   req_addr;
  logic [3:0]    req_ready;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_q;
  logic [3:0]    rsp_valid;
  logic [7:0]    rsp_data;
  logic          busy;

  logic [7:0]    rom [0:2047];
  logic [10:0]   b2b [0:2];
  logic [3:0]    g;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl [0:11];

  typedef struct {
    bit         v;
    int         lane;
    logic [7:0] data;
  } exp_t;
  exp_t pipe [0:1];
  int   mptr = 0;

  act_lut_arbiter #(
    .NUM_REQ   (4),
    .ADDR_W    (11),
    .DATA_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    req_addr = '0;
    for (int i = 0; i < 4; i++) req_addr[i*11 +: 11] = addr[i];
  end

  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    cyc();
    rst = 1'b1;
    rv  = 4'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: arbitration by rotating priority, responses via delay line.
  always @(negedge clk) begin : p_mon
    int         eg;
    int         j;
    exp_t       e;
    logic [3:0] er;
    logic [10:0] ea;
    bit         bz;
    if (rst) begin
      pipe[0].v = 1'b0;
      pipe[1].v = 1'b0;
      mptr      = 0;
    end
    eg = -1;
    for (int k = 0; k < N; k++) begin
      j = (mptr + k) % N;
      if (eg < 0 && rv[j]) eg = j;
    end
    er = (eg >= 0) ? 4'(1 << eg) : 4'h0;
    ea = (eg >= 0) ? addr[eg] : 11'h0;
    check("mon_ready", 32'(req_ready), 32'(er));
    check("mon_rom_addr", 32'(rom_addr), 32'(ea));
    bz = pipe[0].v || (LAT == 2 && pipe[1].v);
    e  = pipe[LAT-1];
    check("mon_rsp_valid", 32'(rsp_valid), e.v ? 32'(1 << e.lane) : 32'd0);
    if (e.v) check("mon_rsp_data", 32'(rsp_data), 32'(e.data));
    check("mon_busy", 32'(busy), 32'(bz));
    pipe[1]      = pipe[0];
    pipe[0].v    = (eg >= 0) && !rst;
    pipe[0].lane = eg;
    pipe[0].data = (eg >= 0) ? rom[addr[eg]] : 8'h0;
    if (eg >= 0 && !rst) mptr = (eg + 1) % N;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", n_tests);
    $fatal(1);
  end

  initial begin
    logic [10:0] caddr [0:3];
    rst = 1'b1;
    rv  = 4'b0;
    for (int i = 0; i < 4; i++) addr[i] = 11'h0;
    for (int a = 0; a < 2048; a++) rom[a] = 8'($urandom);
    rom[11'h3A5] = 8'h7C;

    tbl[0]  = '{4'b0001, 4'b0001};
    tbl[1]  = '{4'b0000, 4'b0000};
    tbl[2]  = '{4'b0100, 4'b0100};
    tbl[3]  = '{4'b1001, 4'b1000};
    tbl[4]  = '{4'b1001, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b1000};
    tbl[8]  = '{4'b0110, 4'b0010};
    tbl[9]  = '{4'b0110, 4'b0100};
    tbl[10] = '{4'b0011, 4'b0001};
    tbl[11] = '{4'b0011, 4'b0010};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_data", 32'(rsp_data), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rom_addr", 32'(rom_addr), 32'd0);
    cyc();
    rv = 4'b0001;
    addr[0] = 11'h123;
    @(negedge clk);
    check("idle_first_grant", 32'(req_ready), 32'h1);
    cyc();
    rv = 4'b0;

    // Full contention from ptr=0
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      caddr[i] = 11'($urandom);
      addr[i]  = caddr[i];
    end
    for (int c = 0; c < 8 + LAT; c++) begin
      cyc();
      rv = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) check("cont_grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= LAT && c - LAT < 8) begin
        check("cont_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - LAT) % 4)));
        check("cont_rsp_data", 32'(rsp_data), 32'(rom[caddr[(c - LAT) % 4]]));
      end
    end

    // Table-driven grant sequence from ptr=0
    do_reset(2);
    for (int t = 0; t < 12; t++) begin
      cyc();
      rv = tbl[t].rv;
      for (int i = 0; i < 4; i++) addr[i] = 11'($urandom);
      @(negedge clk);
      check("table_grant", 32'(req_ready), 32'(tbl[t].exp));
    end
    cyc();
    rv = 4'b0;

    // Single lane with known ROM content
    cyc();
    rv = 4'b0100;
    addr[2] = 11'h3A5;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'h4);
    check("single_rom_addr", 32'(rom_addr), 32'h3A5);
    cyc();
    rv = 4'b0;
    repeat (LAT - 1) cyc();
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'h4);
    check("single_rsp_data", 32'(rsp_data), 32'h7C);

    // Wrap: ptr is 3 after the lane 2 grant
    cyc();
    rv = 4'b1001;
    @(negedge clk);
    check("wrap_first", 32'(req_ready), 32'h8);
    cyc();
    rv = 4'b0001;
    @(negedge clk);
    check("wrap_second", 32'(req_ready), 32'h1);
    cyc();
    rv = 4'b1111;
    @(negedge clk);
    check("wrap_ptr1", 32'(req_ready), 32'h2);
    cyc();
    rv = 4'b0;
    repeat (3) cyc();

    // Back-to-back from lane 1
    b2b[0] = 11'h000;
    b2b[1] = 11'h7FF;
    b2b[2] = 11'h400;
    for (int c = 0; c < 3 + LAT; c++) begin
      cyc();
      if (c < 3) begin
        rv      = 4'b0010;
        addr[1] = b2b[c];
      end else begin
        rv = 4'b0;
      end
      @(negedge clk);
      if (c >= LAT) begin
        check("b2b_rsp_valid", 32'(rsp_valid), 32'h2);
        check("b2b_rsp_data", 32'(rsp_data), 32'(rom[b2b[c - LAT]]));
      end
    end

    // Reset while a response is in flight
    cyc();
    rv = 4'b0001;
    @(negedge clk);
    check("midrst_grant", 32'(req_ready), 32'h1);
    cyc();
    rst = 1'b1;
    rv  = 4'b0;
    @(negedge clk);
    check("midrst_during", 32'(rsp_valid), 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_after", 32'(rsp_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      cyc();
    end

    // Randomized traffic obeying the hold-until-ready handshake
    rv = 4'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g = req_ready;
      cyc();
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] || g[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            rv[i] = 1'b1;
            case ($urandom_range(0, 5))
              0:       addr[i] = 11'h000;
              1:       addr[i] = 11'h7FF;
              default: addr[i] = 11'($urandom);
            endcase
          end else begin
            rv[i] = 1'b0;
          end
        end
      end
    end
    rv = 4'b0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
